bitcoin_sha256d: RTL and testbench

// - Tiny Tapeout user block: computes Bitcoin block hash SHA256(SHA256(header)) of an 80-byte header.
// - Header is fetched byte-by-byte over a request/ready handshake; 32-byte digest is returned the same way.
// - Top-level user macro; the only logic between chip pads and hashing datapath.

---
 rtl/bitcoin_pkg.sv | 61 ++++++
 rtl/sha256_compress.sv | 75 +++++++
 rtl/bitcoin_sha256d.sv | 175 +++++++++++++++++
 tb/tb_bitcoin_sha256d.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitcoin_pkg.sv
// Shared constants, state encoding and SHA-256 helper functions for the
// Bitcoin double-SHA-256 block.
package bitcoin_pkg;

    localparam int HDR_BYTES = 80;
    localparam int DIG_BYTES = 32;
    localparam int ROUNDS    = 64;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV = {H0[0], H0[1], H0[2], H0[3],
                                   H0[4], H0[5], H0[6], H0[7]};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HASH1,
        ST_HASH2,
        ST_HASH3,
        ST_OUTPUT
    } state_t;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, message schedule kept
// in a 16-word sliding window, chaining state added back after round 63.
module sha256_compress
    import bitcoin_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [255:0] h_in,
    input  logic [511:0] block_in,
    output logic         done,
    output logic [255:0] h_out
);

    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  w [16];
    logic [255:0] chain;
    logic [5:0]   round;
    logic         busy;
    logic [31:0]  t1, t2, w_next;

    // w[0] is always W_t for the current round; w[15] receives W_{t+16}
    always_comb begin
        t1     = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[round] + w[0];
        t2     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            chain <= '0;
            round <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                {a, b, c, d, e, f, g, h} <= h_in;
                chain <= h_in;
                for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
                round <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                h <= g;
                g <= f;
                f <= e;
                e <= d + t1;
                d <= c;
                c <= b;
                b <= a;
                a <= t1 + t2;
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_next;
                round <= round + 6'd1;
                if (round == 6'(ROUNDS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    chain[255:224] <= chain[255:224] + t1 + t2;
                    chain[223:192] <= chain[223:192] + a;
                    chain[191:160] <= chain[191:160] + b;
                    chain[159:128] <= chain[159:128] + c;
                    chain[127:96]  <= chain[127:96]  + d + t1;
                    chain[95:64]   <= chain[95:64]   + e;
                    chain[63:32]   <= chain[63:32]   + f;
                    chain[31:0]    <= chain[31:0]    + g;
                end
            end
        end
    end

    assign h_out = chain;

endmodule

// File: rtl/bitcoin_sha256d.sv
// Tiny Tapeout top: fetches an 80-byte header over rq/rdy, computes
// SHA256(SHA256(header)) and returns the 32-byte digest over the same handshake.
module bitcoin_sha256d
    import bitcoin_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [6:0] LAST_HDR = 7'(HDR_BYTES - 1);
    localparam logic [6:0] LAST_DIG = 7'(DIG_BYTES - 1);

    state_t       state, state_d;
    logic [6:0]   cnt, cnt_d;
    logic         rq, rq_d;
    logic         done_r, done_d;
    logic         load, load_d;
    logic         hdr_we;
    logic [7:0]   hdr [HDR_BYTES];
    logic         start, rdy, accept;
    logic         cmp_done;
    logic [255:0] cmp_state, cmp_h_in, dig_shift;
    logic [511:0] block1, block2, block3, cmp_block;
    logic         unused_inputs;

    assign start         = uio_in[0];
    assign rdy           = uio_in[1];
    assign accept        = rq & rdy;
    assign unused_inputs = &{1'b0, ena, uio_in[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rq     <= 1'b0;
            done_r <= 1'b0;
            load   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rq     <= rq_d;
            done_r <= done_d;
            load   <= load_d;
        end
    end

    // rq re-rises only once rdy has been seen low, so each byte gets a fresh request edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rq_d    = rq;
        done_d  = done_r;
        load_d  = 1'b0;
        hdr_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    rq_d   = 1'b0;
                    hdr_we = 1'b1;
                    if (cnt == LAST_HDR) begin
                        state_d = ST_HASH1;
                        cnt_d   = '0;
                        load_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end else if (!rq && !rdy) begin
                    rq_d = 1'b1;
                end
            end
            ST_HASH1: begin
                if (cmp_done) begin
                    state_d = ST_HASH2;
                    load_d  = 1'b1;
                end
            end
            ST_HASH2: begin
                if (cmp_done) begin
                    state_d = ST_HASH3;
                    load_d  = 1'b1;
                end
            end
            ST_HASH3: begin
                if (cmp_done) begin
                    state_d = ST_OUTPUT;
                    done_d  = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (accept) begin
                    rq_d = 1'b0;
                    if (cnt == LAST_DIG) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end else if (!rq && !rdy) begin
                    rq_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < HDR_BYTES; n++) hdr[n] <= '0;
        end else if (hdr_we) begin
            hdr[cnt] <= ui_in;
        end
    end

    // Padded message blocks: header split 64+16 bytes, then the 32-byte first digest
    always_comb begin
        block1 = '0;
        block2 = '0;
        for (int n = 0; n < 64; n++) block1[511-8*n -: 8] = hdr[n];
        for (int n = 0; n < 16; n++) block2[511-8*n -: 8] = hdr[64+n];
        block2[383:376] = 8'h80;
        block2[63:0]    = 64'd640;
        block3 = {cmp_state, 8'h80, 184'd0, 64'd256};
    end

    always_comb begin
        cmp_h_in  = IV;
        cmp_block = block1;
        case (state)
            ST_HASH2: begin
                cmp_h_in  = cmp_state;
                cmp_block = block2;
            end
            ST_HASH3: cmp_block = block3;
            default: ;
        endcase
    end

    sha256_compress u_compress (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .h_in     (cmp_h_in),
        .block_in (cmp_block),
        .done     (cmp_done),
        .h_out    (cmp_state)
    );

    assign dig_shift = cmp_state << {cnt[4:0], 3'b000};

    always_comb begin
        uo_out = 8'h00;
        case (state)
            ST_FETCH:  uo_out = {1'b0, cnt};
            ST_OUTPUT: uo_out = dig_shift[255:248];
            default:   uo_out = 8'h00;
        endcase
    end

    assign uio_out = {4'b0000, done_r, rq, 2'b00};
    assign uio_oe  = 8'b0000_1100;

endmodule

// File: tb/tb_bitcoin_sha256d.sv
// Self-checking bench for bitcoin_sha256d: table of headers with expected
// digests, host handshake model, digest scoreboard and reset/stall/start corner cases.
module tb_bitcoin_sha256d;

    typedef struct {
        logic [639:0] hdr;
        logic [255:0] digest;
        int           stall_fetch;
        int           stall_out;
        bit           glitch;
    } vec_t;

    localparam logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV_REF = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GENESIS_DIG = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       rq, done;

    int         total = 0;
    int         bad = 0;
    bit         aborted = 1'b0;
    logic [7:0] sb_q [$];
    vec_t       vecs [5];

    always #5 clk = ~clk;

    bitcoin_sha256d dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign rq   = uio_out[2];
    assign done = uio_out[3];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Output-enable pattern and unused output bits must never move
    always @(negedge clk) begin
        checkOutput("uio_oe/spare bits", {16'h0, uio_oe, uio_out & 8'hF3}, 32'h0000_0C00);
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] wv [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) wv[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3);
            s1 = rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10);
            wv[t] = wv[t-16] + s0 + wv[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KM[t] + wv[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] model_sha256d(input logic [639:0] hdr);
        logic [255:0] d1;
        d1 = model_compress(model_compress(IV_REF, hdr[639:128]), {hdr[127:0], 8'h80, 312'd0, 64'd640});
        return model_compress(IV_REF, {d1, 8'h80, 184'd0, 64'd256});
    endfunction

    // Host side of one byte transfer; fetch phase supplies data, output phase checks it
    task automatic serveRequest(input bit fetch_phase, input int idx, input int stall,
                                input bit glitch, input logic [639:0] hdr);
        int         waited;
        logic       prev_done;
        logic [7:0] data, held, exp_byte;
        if (aborted) return;
        waited    = 0;
        prev_done = done;
        while (rq !== 1'b1 && waited < 400) begin
            prev_done = done;
            uio_in[0] = (glitch && !fetch_phase && idx == 0 && waited == 100);
            @(negedge clk);
            waited++;
        end
        uio_in[0] = 1'b0;
        if (rq !== 1'b1) begin
            checkOutput(fetch_phase ? "fetch rq timeout" : "output rq timeout", 32'(rq), 32'd1);
            aborted = 1'b1;
            return;
        end
        if (fetch_phase) begin
            checkOutput("fetch addr", 32'(uo_out), 32'(idx));
            checkOutput("done low in fetch", 32'(done), 32'd0);
            data = hdr[639-8*idx -: 8];
        end else begin
            exp_byte = 8'h00;
            if (sb_q.size() > 0) exp_byte = sb_q.pop_front();
            checkOutput("digest byte", 32'(uo_out), 32'(exp_byte));
            checkOutput("done high in output", 32'(done), 32'd1);
            if (idx == 0) checkOutput("done before first rq", 32'(prev_done), 32'd1);
            data = 8'h00;
        end
        held = uo_out;
        repeat (stall) begin
            @(negedge clk);
            checkOutput("stall hold rq/uo_out", {23'd0, rq, uo_out}, {23'd0, 1'b1, held});
        end
        ui_in     = data;
        uio_in[1] = 1'b1;
        if (glitch && !fetch_phase && idx == 5) uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[1] = 1'b0;
        uio_in[0] = 1'b0;
        ui_in     = 8'h00;
        checkOutput("rq dropped after accept", 32'(rq), 32'd0);
    endtask

    task automatic applyStimulus(input int v);
        int quiet;
        for (int i = 0; i < 32; i++) sb_q.push_back(vecs[v].digest[255-8*i -: 8]);
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        for (int i = 0; i < 80; i++)
            serveRequest(1'b1, i, (i == 5) ? vecs[v].stall_fetch : 0, 1'b0, vecs[v].hdr);
        for (int i = 0; i < 32; i++)
            serveRequest(1'b0, i, (i == 3) ? vecs[v].stall_out : 0, vecs[v].glitch, vecs[v].hdr);
        if (aborted) return;
        checkOutput("done falls with last byte", 32'(done), 32'd0);
        checkOutput("idle uo_out", 32'(uo_out), 32'd0);
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (rq !== 1'b0 || done !== 1'b0) quiet = 1;
        end
        checkOutput("stays idle after run", 32'(quiet), 32'd0);
    endtask

    initial begin
        logic [639:0] rnd;
        int           waited;

        for (int i = 0; i < 20; i++) rnd[639-32*i -: 32] = $urandom;
        vecs[0] = '{hdr: GENESIS, digest: GENESIS_DIG, stall_fetch: 0, stall_out: 0, glitch: 1'b0};
        vecs[1] = '{hdr: GENESIS, digest: GENESIS_DIG, stall_fetch: 7, stall_out: 7, glitch: 1'b0};
        vecs[2] = '{hdr: GENESIS, digest: GENESIS_DIG, stall_fetch: 0, stall_out: 0, glitch: 1'b1};
        vecs[3] = '{hdr: '0, digest: model_sha256d('0), stall_fetch: 0, stall_out: 0, glitch: 1'b0};
        vecs[4] = '{hdr: rnd, digest: model_sha256d(rnd), stall_fetch: 3, stall_out: 2, glitch: 1'b0};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset uo_out", 32'(uo_out), 32'd0);
        checkOutput("reset rq/done", 32'(uio_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle after release uo_out", 32'(uo_out), 32'd0);
        checkOutput("idle after release rq", 32'(rq), 32'd0);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d", v);
            applyStimulus(v);
        end

        // Abort mid-fetch at address 40, then a fresh run must restart at address 0
        if (!aborted) begin
            $display("[TB] reset during fetch");
            uio_in[0] = 1'b1;
            @(negedge clk);
            uio_in[0] = 1'b0;
            for (int i = 0; i < 40; i++) serveRequest(1'b1, i, 0, 1'b0, GENESIS);
            waited = 0;
            while (rq !== 1'b1 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("addr 40 request", {23'd0, rq, uo_out}, {23'd0, 1'b1, 8'd40});
            rst_n = 1'b0;
            #1;
            checkOutput("async reset uo_out", 32'(uo_out), 32'd0);
            checkOutput("async reset rq", 32'(rq), 32'd0);
            checkOutput("async reset done", 32'(done), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            applyStimulus(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
